pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Fetch controller that drives the write side of the program-counter register (`pcreg`) and fetches instructions from instruction memory. It owns PC sequencing: loads the boot address after reset, requests the instruction at the current PC, advances PC by 4 on each accepted fetch, and applies branch/jump redirects. Sits between `pcreg` and the instruction-memory port, feeding the decode stage.

## Interface
- RESET_PC, 32'h0040_0000, boot address written to `pcreg` after reset
- WAIT_MAX, 15, maximum WAIT cycles without `imem_ack` before fetch error (1..255)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_cur  in  32  current PC, from `pcreg` data_out
- pc_next  out  32  next PC, to `pcreg` data_in
- pc_ena  out  1  write enable, to `pcreg` ena
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  fetch complete, `imem_rdata` valid
- imem_rdata  in  32  fetched instruction
- stall  in  1  downstream hold; no new fetch issued
- redir_valid  in  1  redirect request, single-cycle pulse
- redir_target  in  32  redirect address
- instr_valid  out  1  one-cycle pulse, `instr` valid
- instr  out  32  last accepted instruction
- fetch_err  out  1  sticky error flag

## Operation
- States: BOOT, ISSUE, WAIT, ERR. Reset state is BOOT.
- Redirect pending register (`pend_v`, `pend_pc`). Captured on `redir_valid` in BOOT/ISSUE/WAIT; a later redirect overwrites an earlier one. Ignored in ERR.
- BOOT:
  - `pc_ena`=1, `pc_next`=RESET_PC.
  - Next state is ISSUE.
- ISSUE:
  - If a redirect is pending or arriving: `pc_ena`=1, `pc_next`=target, pending cleared, stay in ISSUE. This has priority over `stall`.
  - Else if `stall`: hold, `pc_ena`=0.
  - Else: go to WAIT. Clear the timeout counter.
- WAIT:
  - `imem_req`=1 and `imem_addr`=`pc_cur`, held stable until ack.
  - On `imem_ack` with no pending or arriving redirect: latch `instr`=`imem_rdata`, pulse `instr_valid`, `pc_ena`=1, `pc_next`=`pc_cur`+4 (mod 2^32, wraps 32'hFFFF_FFFC→0). Go to ISSUE.
  - On `imem_ack` with a pending or arriving redirect: discard the data (no `instr_valid`), `pc_ena`=1, `pc_next`=target, clear pending. Go to ISSUE.
  - `stall` is ignored in WAIT; an outstanding request always completes.
  - No ack: counter increments. After WAIT_MAX consecutive no-ack cycles, set `fetch_err` and go to ERR.
- ERR: all requests and writes are 0. Only reset exits this state.
- `pc_next` is `pc_cur`+4 whenever `pc_ena`=0.

## Timing
- Reset values: state BOOT, `instr`=0, `instr_valid`=0, `fetch_err`=0, pending clear, counter 0. `pc_ena`, `imem_req` are 0 while `rst` is high.
- `pc_ena`, `pc_next`, `imem_req`, `imem_addr` are combinational from state and inputs. `instr`, `instr_valid`, `fetch_err` are registered.
- `pcreg` updates on the edge where `pc_ena`=1. `pc_cur` shows the new value in the next cycle, which is the ISSUE cycle.
- Latency from ack to `instr_valid`: 1 cycle.
- Minimum fetch period: 2 cycles (ISSUE + one WAIT cycle with ack in the first cycle).
- Boot to first `imem_req`: 2 cycles after `rst` deasserts.
- Reset asserted mid-fetch: the request drops asynchronously and the in-flight data is discarded.

## Configuration
- `PC_FETCH_ALIGN_CHECK_EN` defined: a redirect whose target has [1:0]≠0 is not written. It sets `fetch_err` and the block goes to ERR on the cycle the redirect would apply.
- Not defined: targets are written verbatim with no alignment check.

## Structure
- Package `pc_fetch_pkg` holds:
  - the state encoding (2-bit localparams)
  - PC_STEP=4
  - the default RESET_PC
  - the counter width
- Sub-module `pc_fetch_timeout`: a clearable WAIT-cycle counter with an `expired` output at WAIT_MAX.

## Test plan
- Release reset → next edge writes `pcreg`=32'h0040_0000. `imem_req` rises with `imem_addr`=32'h0040_0000 two cycles after release.
- Zero-wait memory returns 32'h2002_0005 → `instr_valid` pulse with that `instr`, PC becomes 32'h0040_0004. Steady state is one fetch every 2 cycles.
- `redir_valid` with target 32'h0040_0100 in the same cycle as `imem_ack` → no `instr_valid`, next `imem_addr`=32'h0040_0100.
- `stall` held 5 cycles in ISSUE → no `imem_req`, PC unchanged. A redirect during the stall is written immediately.
- WAIT_MAX=3 and ack withheld → `fetch_err`=1 after the 3rd no-ack cycle. Outputs stay idle until reset. With the macro defined, target 32'h0040_0102 also sets `fetch_err`.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch controller.
package pc_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  typedef enum logic [1:0] {
    BOOT  = ST_BOOT,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    ERR   = ST_ERR
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } redir_t;

endpackage

// File: rtl/pc_fetch_timeout.sv
// Clearable WAIT-cycle counter. expired is high while the next no-ack
// cycle would be the WAIT_MAX-th one.
module pc_fetch_timeout
  import pc_fetch_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

  assign expired = (cnt == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and instruction fetch controller driving pcreg and imem.
// Optional macro PC_FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise fetch_err.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_ena,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        fetch_err
);

  state_t      state, state_nx;
  redir_t      pend, pend_nx;
  logic        redir_any, misaligned;
  logic [31:0] redir_pc, nxt;
  logic        ena, req, iv_nx, instr_ld, err_set;
  logic        to_clr, to_inc, to_expired;

  // An arriving redirect supersedes any pending one.
  assign redir_any = pend.valid | redir_valid;
  assign redir_pc  = redir_valid ? redir_target : pend.pc;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign misaligned = (redir_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  pc_fetch_timeout #(.WAIT_MAX(WAIT_MAX)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .inc     (to_inc),
    .expired (to_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    ena      = 1'b0;
    nxt      = pc_cur + PC_STEP;
    req      = 1'b0;
    iv_nx    = 1'b0;
    instr_ld = 1'b0;
    err_set  = 1'b0;
    to_clr   = 1'b0;
    to_inc   = 1'b0;
    case (state)
      BOOT: begin
        ena      = 1'b1;
        nxt      = RESET_PC;
        state_nx = ISSUE;
        if (redir_valid) pend_nx = '{valid: 1'b1, pc: redir_target};
      end
      ISSUE: begin
        if (redir_any) begin
          pend_nx = '0;
          if (misaligned) begin
            err_set  = 1'b1;
            state_nx = ERR;
          end else begin
            ena = 1'b1;
            nxt = redir_pc;
          end
        end else if (!stall) begin
          state_nx = WAIT;
          to_clr   = 1'b1;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (imem_ack) begin
          state_nx = ISSUE;
          if (redir_any) begin
            // Fetched data belongs to the abandoned path; drop it.
            pend_nx = '0;
            if (misaligned) begin
              err_set  = 1'b1;
              state_nx = ERR;
            end else begin
              ena = 1'b1;
              nxt = redir_pc;
            end
          end else begin
            ena      = 1'b1;
            iv_nx    = 1'b1;
            instr_ld = 1'b1;
          end
        end else begin
          if (redir_valid) pend_nx = '{valid: 1'b1, pc: redir_target};
          if (to_expired) begin
            err_set  = 1'b1;
            state_nx = ERR;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      ERR: begin
      end
      default: state_nx = BOOT;
    endcase
  end

  // Requests and writes are forced low while reset is held.
  assign pc_ena    = ena & ~rst;
  assign imem_req  = req & ~rst;
  assign pc_next   = nxt;
  assign imem_addr = pc_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      pend        <= pend_nx;
      instr_valid <= iv_nx;
      if (instr_ld) instr <= imem_rdata;
      if (err_set)  fetch_err <= 1'b1;
    end
  end

endmodule
